// File: rtl/busio_pkg.sv
// busio shared types: mem_size encodings and the bus controller state enum.
// Imported by busio and busio_lane.
package busio_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MEM,
    FETCH_DONE,
    MEM_DONE
  } state_t;

endpackage

// File: rtl/busio_lane.sv
// busio_lane: combinational byte-lane logic for loads and stores.
// Ports: addr_lo/size/sign_ext select the lane; rdata -> load_data,
// wdata -> store_data + strobe. Size 11 behaves as a word.
module busio_lane
  import busio_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  strobe
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata;
    load_data = rdata;
    case (size)
      MEM_SIZE_BYTE: begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = {{24{sign_ext & shifted[7]}},
                     shifted[7:0]};
      end
      MEM_SIZE_HALF: begin
        shifted   = rdata >> {addr_lo[1], 4'b0000};
        load_data = {{16{sign_ext & shifted[15]}},
                     shifted[15:0]};
      end
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    store_data = wdata;
    strobe     = 4'b1111;
    case (size)
      MEM_SIZE_BYTE: begin
        store_data = {4{wdata[7:0]}};
        strobe     = 4'b0001 << addr_lo;
      end
      MEM_SIZE_HALF: begin
        store_data = {2{wdata[15:0]}};
        strobe     = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        store_data = wdata;
        strobe     = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/busio.sv
// busio: arbitrates fetch and data accesses onto one external bus.
// Ports: clk, reset (async high); fetch_* side, mem_* side, ext_* bus.
// Define BUSIO_FETCH_BUFFER_EN for a one-entry instruction buffer.
module busio
  import busio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  output logic [31:0] mem_load_data,
  output logic        mem_ready,
  output logic        ext_valid,
  output logic        ext_instruction,
  output logic [31:0] ext_address,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  input  logic        ext_ready,
  input  logic [31:0] ext_read_data
);

  state_t state_q, state_d;

  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [1:0]  req_size_q;
  logic        req_signed_q;
  logic        req_store_q;
  logic [31:0] rdata_q;
  logic [31:0] fetch_hold_q;
  logic [31:0] load_hold_q;

  logic        mem_req;
  logic        buf_hit;
  logic [31:0] buf_word;
  logic        bus_done;
  logic        is_idle;
  logic [31:0] lane_load;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_strobe;

  assign mem_req  = mem_load | mem_store;
  assign is_idle  = (state_q == IDLE);
  assign bus_done = ext_ready &
                    ((state_q == FETCH) | (state_q == MEM));

  busio_lane u_lane (
    .addr_lo    (req_addr_q[1:0]),
    .size       (req_size_q),
    .sign_ext   (req_signed_q),
    .rdata      (rdata_q),
    .wdata      (req_wdata_q),
    .load_data  (lane_load),
    .store_data (lane_wdata),
    .strobe     (lane_strobe)
  );

`ifdef BUSIO_FETCH_BUFFER_EN
  logic [31:0] buf_addr_q;
  logic [31:0] buf_word_q;
  logic        buf_valid_q;
  logic        buf_kill;

  assign buf_hit  = buf_valid_q &
                    (buf_addr_q == fetch_address);
  assign buf_word = buf_word_q;
  assign buf_kill = is_idle & mem_store &
                    (mem_address[31:2] == buf_addr_q[31:2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_addr_q  <= '0;
      buf_word_q  <= '0;
      buf_valid_q <= 1'b0;
    end else if (buf_kill) begin
      buf_valid_q <= 1'b0;
    end else if (state_q == FETCH && ext_ready) begin
      buf_addr_q  <= req_addr_q;
      buf_word_q  <= ext_read_data;
      buf_valid_q <= 1'b1;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req)
          state_d = MEM;
        else if (buf_hit)
          state_d = FETCH_DONE;
        else
          state_d = FETCH;
      end
      FETCH:      if (ext_ready) state_d = FETCH_DONE;
      MEM:        if (ext_ready) state_d = MEM_DONE;
      FETCH_DONE: state_d = IDLE;
      MEM_DONE:   state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    ext_valid        = (state_q == FETCH) |
                       (state_q == MEM);
    ext_instruction  = (state_q == FETCH);
    ext_address      = '0;
    ext_write_data   = '0;
    ext_write_strobe = '0;
    if (ext_valid)
      ext_address = {req_addr_q[31:2], 2'b00};
    if (state_q == MEM && req_store_q) begin
      ext_write_data   = lane_wdata;
      ext_write_strobe = lane_strobe;
    end
    // a fetch whose address moved on is dropped silently
    fetch_ready   = (state_q == FETCH_DONE) &
                    (fetch_address == req_addr_q);
    mem_ready     = (state_q == MEM_DONE);
    fetch_data    = fetch_ready ? rdata_q : fetch_hold_q;
    mem_load_data = (mem_ready & ~req_store_q) ?
                    lane_load : load_hold_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_size_q   <= MEM_SIZE_BYTE;
      req_signed_q <= 1'b0;
      req_store_q  <= 1'b0;
      rdata_q      <= '0;
      fetch_hold_q <= '0;
      load_hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (is_idle) begin
        req_addr_q   <= mem_req ? mem_address
                                : fetch_address;
        req_wdata_q  <= mem_store_data;
        req_size_q   <= mem_size;
        req_signed_q <= mem_signed;
        req_store_q  <= mem_store;
        if (!mem_req && buf_hit)
          rdata_q <= buf_word;
      end
      if (bus_done)
        rdata_q <= ext_read_data;
      if (fetch_ready)
        fetch_hold_q <= rdata_q;
      if (mem_ready && !req_store_q)
        load_hold_q <= lane_load;
    end
  end

endmodule

// File: tb/tb_busio.sv
// tb_busio: random + directed bench for busio against a byte-level
// memory reference model with a randomly stalling bus slave.
module tb_busio;
  import busio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_address = 32'h100;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_store_data = '0;
  logic [1:0]  mem_size = '0;
  logic        mem_signed = 1'b0;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [31:0] mem_load_data;
  logic        mem_ready;
  logic        ext_valid;
  logic        ext_instruction;
  logic [31:0] ext_address;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_write_strobe;
  logic        ext_ready = 1'b0;
  logic [31:0] ext_read_data = '0;

  busio dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_address    (fetch_address),
    .fetch_data       (fetch_data),
    .fetch_ready      (fetch_ready),
    .mem_address      (mem_address),
    .mem_store_data   (mem_store_data),
    .mem_size         (mem_size),
    .mem_signed       (mem_signed),
    .mem_load         (mem_load),
    .mem_store        (mem_store),
    .mem_load_data    (mem_load_data),
    .mem_ready        (mem_ready),
    .ext_valid        (ext_valid),
    .ext_instruction  (ext_instruction),
    .ext_address      (ext_address),
    .ext_write_data   (ext_write_data),
    .ext_write_strobe (ext_write_strobe),
    .ext_ready        (ext_ready),
    .ext_read_data    (ext_read_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [0:1023];
  logic [31:0] bus_mem [0:1023];

  logic        stall_en = 1'b0;
  logic [31:0] stall_addr = '0;

  logic        cur_active = 1'b0;
  logic        cur_store = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_data = '0;
  logic [1:0]  cur_size = '0;
  logic        cur_signed = 1'b0;

  logic [31:0] last_load = '0;
  logic [31:0] last_fetch = '0;
  logic [31:0] last_st_addr = '0;
  logic [31:0] last_st_data = '0;
  logic [3:0]  last_st_strb = '0;
  int          mem_rdy_cnt = 0;
  int          fetch_rdy_cnt = 0;
  int          valid_cycles = 0;
  logic [31:0] t_e;
  logic [31:0] t_d;
  logic [3:0]  t_s;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(
    input logic [31:0] a, input logic [1:0] sz,
    input logic sg);
    logic [31:0] w;
    logic [31:0] v;
    w = ref_mem[a[11:2]];
    if (sz == 2'd0) begin
      v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_wdata(
    input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] exp_strb(
    input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 4'b0001 << a[1:0];
    if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // bus slave plus monitor; everything sampled on the falling edge
  always @(negedge clk) begin
    ext_ready = 1'b0;
    if (ext_valid &&
        !(stall_en && ext_address == stall_addr) &&
        $urandom_range(0, 2) != 0)
      ext_ready = 1'b1;
    ext_read_data = bus_mem[ext_address[11:2]];
    if (ext_valid && ext_ready)
      for (int i = 0; i < 4; i++)
        if (ext_write_strobe[i])
          bus_mem[ext_address[11:2]][8*i +: 8] =
            ext_write_data[8*i +: 8];
    if (reset) begin
      last_load  = '0;
      last_fetch = '0;
    end else begin
      if (ext_valid) valid_cycles++;
      if (ext_valid && ext_ready && !ext_instruction &&
          cur_active) begin
        check("bus_addr", ext_address,
              {cur_addr[31:2], 2'b00});
        if (cur_store) begin
          last_st_addr = ext_address;
          last_st_data = ext_write_data;
          last_st_strb = ext_write_strobe;
          check("bus_wdata", ext_write_data,
                exp_wdata(cur_data, cur_size));
          check("bus_strb", {28'd0, ext_write_strobe},
                {28'd0, exp_strb(cur_addr, cur_size)});
        end else begin
          check("load_strb", {28'd0, ext_write_strobe}, 0);
        end
      end
      if (mem_ready) begin
        mem_rdy_cnt++;
        if (cur_active && !cur_store) begin
          t_e = exp_load(cur_addr, cur_size, cur_signed);
          check("load_data", mem_load_data, t_e);
          last_load = t_e;
        end else begin
          check("load_hold", mem_load_data, last_load);
          if (cur_active) begin
            t_d = exp_wdata(cur_data, cur_size);
            t_s = exp_strb(cur_addr, cur_size);
            for (int i = 0; i < 4; i++)
              if (t_s[i])
                ref_mem[cur_addr[11:2]][8*i +: 8] =
                  t_d[8*i +: 8];
          end
        end
      end else begin
        check("load_hold", mem_load_data, last_load);
      end
      if (fetch_ready) begin
        fetch_rdy_cnt++;
        t_e = ref_mem[fetch_address[11:2]];
        check("fetch_data", fetch_data, t_e);
        last_fetch = t_e;
      end else begin
        check("fetch_hold", fetch_data, last_fetch);
      end
    end
  end

  task automatic start_op(input logic st,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [1:0] sz,
                          input logic sg);
    cur_store  = st;
    cur_addr   = a;
    cur_data   = d;
    cur_size   = sz;
    cur_signed = sg;
    cur_active = 1'b1;
    mem_address    = a;
    mem_store_data = d;
    mem_size       = sz;
    mem_signed     = sg;
    mem_store      = st;
    mem_load       = st ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic finish_op(output logic [31:0] obs);
    logic got;
    got = 1'b0;
    obs = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        got = 1'b1;
        obs = mem_load_data;
        break;
      end
    end
    if (!got) check("mem_timeout", 0, 1);
    @(posedge clk);
    #1;
    mem_load   = 1'b0;
    mem_store  = 1'b0;
    cur_active = 1'b0;
    mem_address = $urandom;
  endtask

  task automatic mem_op(input logic st,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [1:0] sz,
                        input logic sg,
                        output logic [31:0] obs);
    @(posedge clk);
    #1;
    start_op(st, a, d, sz, sg);
    finish_op(obs);
  endtask

  task automatic wait_bus(input logic instr,
                          input logic [31:0] a,
                          input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ext_valid && ext_instruction == instr &&
          ext_address == a) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, got}, 1);
  endtask

  logic [31:0] obs;
  int          cnt;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    ref_mem[32'h100 >> 2] = 32'h80FF_0000;
    bus_mem[32'h100 >> 2] = 32'h80FF_0000;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, ext_valid}, 0);
    check("rst_fready", {31'd0, fetch_ready}, 0);
    check("rst_mready", {31'd0, mem_ready}, 0);
    check("rst_strb", {28'd0, ext_write_strobe}, 0);
    check("rst_fdata", fetch_data, 0);
    check("rst_ldata", mem_load_data, 0);
    check("rst_addr", ext_address, 0);
    check("rst_wdata", ext_write_data, 0);

    // load and fetch both pending when IDLE is first seen
    fetch_address = 32'h100;
    start_op(1'b0, 32'h103, 32'h0, MEM_SIZE_BYTE, 1'b1);
    mem_rdy_cnt   = 0;
    fetch_rdy_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("prio_first_is_mem", {31'd0, ext_instruction}, 0);
    finish_op(obs);
    check("lb_signed", obs, 32'hFFFF_FF80);
    check("fetch_before_mem", fetch_rdy_cnt, 0);
    for (int i = 0; i < 100 && fetch_rdy_cnt == 0; i++)
      @(negedge clk);
    check("fetch_after_mem", {31'd0, fetch_rdy_cnt > 0}, 1);

    mem_op(1'b0, 32'h103, 32'h0, MEM_SIZE_BYTE, 1'b0, obs);
    check("lb_unsigned", obs, 32'h0000_0080);

    mem_op(1'b1, 32'h202, 32'h0000_BEEF, MEM_SIZE_HALF,
           1'b0, obs);
    check("sh_addr", last_st_addr, 32'h200);
    check("sh_wdata", last_st_data, 32'hBEEF_BEEF);
    check("sh_strb", {28'd0, last_st_strb}, 32'hC);

`ifdef BUSIO_FETCH_BUFFER_EN
    @(posedge clk);
    #1;
    fetch_address = 32'h100;
    cnt = fetch_rdy_cnt;
    for (int i = 0; i < 200 && fetch_rdy_cnt < cnt + 2; i++)
      @(negedge clk);
    cnt = valid_cycles;
    repeat (12) @(negedge clk);
    check("buf_no_bus", valid_cycles - cnt, 0);
    mem_op(1'b1, 32'h100, $urandom, MEM_SIZE_WORD,
           1'b0, obs);
    wait_bus(1'b1, 32'h100, "buf_refetch_after_store");
`endif

    // stale fetch: address moves while the bus is stalled
    @(posedge clk);
    #1;
    fetch_address = 32'h300;
    repeat (20) @(posedge clk);
    #1;
    stall_addr    = 32'h100;
    stall_en      = 1'b1;
    fetch_address = 32'h100;
    wait_bus(1'b1, 32'h100, "stale_req");
    repeat (3) begin
      @(negedge clk);
      check("stall_hold_addr", ext_address, 32'h100);
    end
    @(posedge clk);
    #1;
    fetch_address = 32'h400;
    cnt = fetch_rdy_cnt;
    stall_en = 1'b0;
    wait_bus(1'b1, 32'h400, "next_fetch_400");
    check("stale_dropped", fetch_rdy_cnt - cnt, 0);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        fetch_address = {20'd0, 10'($urandom), 2'b00};
      end
      mem_op(1'($urandom_range(0, 2) == 0),
             {20'd0, 12'($urandom)}, $urandom,
             2'($urandom), 1'($urandom), obs);
    end

    // reset while a data access is stalled on the bus
    @(posedge clk);
    #1;
    fetch_address = 32'h040;
    stall_addr    = 32'h500;
    stall_en      = 1'b1;
    start_op(1'b0, 32'h501, 32'h0, MEM_SIZE_HALF, 1'b1);
    wait_bus(1'b0, 32'h500, "mem_in_flight");
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, ext_valid}, 0);
    check("rst_mid_strb", {28'd0, ext_write_strobe}, 0);
    check("rst_mid_mready", {31'd0, mem_ready}, 0);
    check("rst_mid_ldata", mem_load_data, 0);
    check("rst_mid_fdata", fetch_data, 0);
    mem_load   = 1'b0;
    cur_active = 1'b0;
    stall_en   = 1'b0;
    cnt = mem_rdy_cnt;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_mready", mem_rdy_cnt - cnt, 0);
    mem_op(1'b0, 32'h501, 32'h0, MEM_SIZE_HALF, 1'b1, obs);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
